// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending machine sequencer.
//   - FSM state encoding
//   - keypad codes for coins, product selects and cancel
//   - coin values and the change step
package vend_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StCredit = 2'd1,
      StVend   = 2'd2,
      StChange = 2'd3
   } vend_state_e;

   localparam logic [3:0] KEY_COIN5  = 4'h1;
   localparam logic [3:0] KEY_COIN10 = 4'h2;
   localparam logic [3:0] KEY_COIN25 = 4'h3;
   localparam logic [3:0] KEY_COIN50 = 4'h4;
   localparam logic [3:0] KEY_SEL0   = 4'hA;
   localparam logic [3:0] KEY_SEL1   = 4'hB;
   localparam logic [3:0] KEY_SEL2   = 4'hC;
   localparam logic [3:0] KEY_SEL3   = 4'hD;
   localparam logic [3:0] KEY_CANCEL = 4'hE;

   localparam logic [7:0] COIN5_VAL  = 8'd5;
   localparam logic [7:0] COIN10_VAL = 8'd10;
   localparam logic [7:0] COIN25_VAL = 8'd25;
   localparam logic [7:0] COIN50_VAL = 8'd50;

   localparam logic [7:0] CHANGE_UNIT = 8'd5;

   // Credit value of a coin key; zero for anything that is not a coin.
   function automatic logic [7:0] coin_value(input logic [3:0] code);
      logic [7:0] v;
      case (code)
         KEY_COIN5:  v = COIN5_VAL;
         KEY_COIN10: v = COIN10_VAL;
         KEY_COIN25: v = COIN25_VAL;
         KEY_COIN50: v = COIN50_VAL;
         default:    v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_timer.sv
// vend_timer: loadable down-counter with a done flag.
//   clk, reset (async, active low), load/load_val (load has priority),
//   en (count down, holding at zero), done (count is zero).
module vend_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/vend_controller.sv
// vend_controller: vending machine sequencer.
//   Inputs : clk, reset (async, active low), key_valid, key_code[3:0]
//   Outputs: credit[7:0], dispense, product[1:0], change_coin, coin_reject,
//            error, busy
//   Optional build macro VEND_AUDIT_EN adds sales_total[15:0] (saturating sum
//   of prices sold) and vend_count[7:0] (wrapping vend counter).
module vend_controller
   import vend_pkg::*;
#(
   parameter int unsigned PRICE0          = 25,
   parameter int unsigned PRICE1          = 50,
   parameter int unsigned PRICE2          = 75,
   parameter int unsigned PRICE3          = 100,
   parameter int unsigned MAX_CREDIT      = 200,
   parameter logic [3:0]  STOCK_INIT      = 4'd9,
   parameter int unsigned DISPENSE_CYCLES = 8,
   parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [7:0] credit,
   output logic       dispense,
   output logic [1:0] product,
   output logic       change_coin,
   output logic       coin_reject,
   output logic       error,
   output logic       busy
`ifdef VEND_AUDIT_EN
   ,
   output logic [15:0] sales_total,
   output logic [7:0]  vend_count
`endif
);

   vend_state_e state_q, state_d;
   logic [7:0]  credit_q, credit_d;
   logic [3:0]  stock_q [4];
   logic [3:0]  stock_d [4];
   logic [1:0]  product_q, product_d;
   logic        phase_q, phase_d;
   logic        reject_q, reject_d;
   logic        error_q, error_d;

   logic        is_coin, is_sel, is_cancel;
   logic [7:0]  coin_val;
   logic [8:0]  coin_sum;
   logic [1:0]  sel_idx;
   logic [7:0]  sel_price;
   logic        vend_load, vend_done, tmo_load, tmo_done;

   // Key decode
   always_comb begin
      coin_val  = coin_value(key_code);
      is_coin   = (coin_val != 8'd0);
      is_sel    = (key_code >= KEY_SEL0) && (key_code <= KEY_SEL3);
      is_cancel = (key_code == KEY_CANCEL);
      sel_idx   = 2'(key_code - KEY_SEL0);
      coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
      case (sel_idx)
         2'd0:    sel_price = 8'(PRICE0);
         2'd1:    sel_price = 8'(PRICE1);
         2'd2:    sel_price = 8'(PRICE2);
         default: sel_price = 8'(PRICE3);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      stock_d   = stock_q;
      product_d = product_q;
      phase_d   = phase_q;
      reject_d  = 1'b0;
      error_d   = 1'b0;
      vend_load = 1'b0;
      unique case (state_q)
         StIdle, StCredit: begin
            if (key_valid) begin
               if (is_coin) begin
                  if (coin_sum <= 9'(MAX_CREDIT)) begin
                     credit_d = coin_sum[7:0];
                     state_d  = StCredit;
                  end else begin
                     reject_d = 1'b1;
                  end
               end else if (is_sel) begin
                  if ((stock_q[sel_idx] == 4'd0) || (credit_q < sel_price)) begin
                     error_d = 1'b1;
                  end else begin
                     credit_d         = credit_q - sel_price;
                     stock_d[sel_idx] = stock_q[sel_idx] - 4'd1;
                     product_d        = sel_idx;
                     vend_load        = 1'b1;
                     state_d          = StVend;
                  end
               end else if (is_cancel && (state_q == StCredit)) begin
                  state_d = StChange;
                  phase_d = 1'b0;
               end
            end else if ((state_q == StCredit) && tmo_done) begin
               state_d = StChange;
               phase_d = 1'b0;
            end
         end
         StVend: begin
            if (vend_done) begin
               state_d = (credit_q != 8'd0) ? StChange : StIdle;
               phase_d = 1'b0;
            end
         end
         StChange: begin
            // phase_q low on the entry cycle, so pulses land on alternate
            // cycles starting one cycle after entry.
            phase_d = ~phase_q;
            if (phase_q) begin
               credit_d = credit_q - CHANGE_UNIT;
               if (credit_q == CHANGE_UNIT) begin
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         credit_q  <= 8'd0;
         product_q <= 2'd0;
         phase_q   <= 1'b0;
         reject_q  <= 1'b0;
         error_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            stock_q[i] <= STOCK_INIT;
         end
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         product_q <= product_d;
         phase_q   <= phase_d;
         reject_q  <= reject_d;
         error_q   <= error_d;
         stock_q   <= stock_d;
      end
   end

   // Any key seen while accepting keys restarts the idle timeout.
   assign tmo_load = key_valid && ((state_q == StIdle) || (state_q == StCredit));

   vend_timer #(
      .WIDTH(8)
   ) u_dispense_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (vend_load),
      .load_val (8'(DISPENSE_CYCLES - 1)),
      .en       (state_q == StVend),
      .done     (vend_done)
   );

   vend_timer #(
      .WIDTH(24)
   ) u_timeout_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmo_load),
      .load_val (TIMEOUT_CYCLES - 24'd1),
      .en       (state_q == StCredit),
      .done     (tmo_done)
   );

   assign credit      = credit_q;
   assign dispense    = (state_q == StVend);
   assign product     = dispense ? product_q : 2'd0;
   assign change_coin = (state_q == StChange) && phase_q;
   assign coin_reject = reject_q;
   assign error       = error_q;
   assign busy        = (state_q == StVend) || (state_q == StChange);

`ifdef VEND_AUDIT_EN
   logic [15:0] sales_q;
   logic [7:0]  count_q;
   logic [16:0] sales_sum;

   assign sales_sum = {1'b0, sales_q} + {9'd0, sel_price};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sales_q <= 16'd0;
         count_q <= 8'd0;
      end else if (vend_load) begin
         sales_q <= sales_sum[16] ? 16'hFFFF : sales_sum[15:0];
         count_q <= count_q + 8'd1;
      end
   end

   assign sales_total = sales_q;
   assign vend_count  = count_q;
`endif

endmodule
